alu_issue_stage: RTL and testbench

//  Two-stage issue/writeback wrapper that drives the 8-bit combinational ALU: accepts ops over valid/ready,

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_flag_reg.sv | 77 +++++++
 rtl/alu_issue_stage.sv | 174 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding and decode helpers for the ALU issue/writeback stage.
package alu_pkg;

    localparam int W   = 8;
    localparam int OPW = 4;
    localparam int SCW = 3;
    localparam int FNW = 5;

    localparam logic [OPW-1:0] OP_ADD  = 4'd0;
    localparam logic [OPW-1:0] OP_ADDC = 4'd1;
    localparam logic [OPW-1:0] OP_SUB  = 4'd2;
    localparam logic [OPW-1:0] OP_SUBC = 4'd3;
    localparam logic [OPW-1:0] OP_AND  = 4'd4;
    localparam logic [OPW-1:0] OP_OR   = 4'd5;
    localparam logic [OPW-1:0] OP_XOR  = 4'd6;
    localparam logic [OPW-1:0] OP_MASK = 4'd7;
    localparam logic [OPW-1:0] OP_SHL  = 4'd8;
    localparam logic [OPW-1:0] OP_SHR  = 4'd9;
    localparam logic [OPW-1:0] OP_ROL  = 4'd10;
    localparam logic [OPW-1:0] OP_ROR  = 4'd11;

    function automatic logic uses_cin(input logic [OPW-1:0] op);
        return (op == OP_ADDC) || (op == OP_SUBC);
    endfunction

    // Arithmetic and shift/rotate ops produce a carry; logical ops and illegal codes do not.
    function automatic logic sets_carry(input logic [OPW-1:0] op);
        return (op <= OP_SUBC) || ((op >= OP_SHL) && (op <= OP_ROR));
    endfunction

    function automatic logic is_illegal(input logic [OPW-1:0] op);
        return op > OP_ROR;
    endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// Architectural carry/zero flags with retire-time commit and carry-in selection.
// ALU_ISSUE_FLAG_FWD_EN selects forwarding of the WB carry instead of stalling on it.
module alu_flag_reg (
    input  logic clk,
    input  logic rst_n,
    input  logic ex_valid,
    input  logic ex_uses_cin,
    input  logic wb_pending,
    input  logic wb_ready,
    input  logic wb_illegal,
    input  logic wb_sets_carry,
    input  logic wb_cout,
    input  logic wb_zero,
    output logic carry_flag,
    output logic zero_flag,
    output logic alu_cin,
    output logic hazard
);

    logic carry_q, carry_d;
    logic zero_q, zero_d;
    logic commit_s;
    logic cin_src_s;

    // Retire-time flag update; logical ops leave the carry untouched.
    always_comb begin
        carry_d  = carry_q;
        zero_d   = zero_q;
        commit_s = wb_pending && wb_ready && !wb_illegal;
        if (commit_s) begin
            zero_d = wb_zero;
            if (wb_sets_carry) begin
                carry_d = wb_cout;
            end else begin
                carry_d = carry_q;
            end
        end else begin
            zero_d  = zero_q;
            carry_d = carry_q;
        end
    end

    // Carry-in source for EX and the stall request when the WB carry is not yet committed.
    always_comb begin
`ifdef ALU_ISSUE_FLAG_FWD_EN
        hazard = 1'b0;
        if (wb_pending && !wb_illegal && wb_sets_carry) begin
            cin_src_s = wb_cout;
        end else begin
            cin_src_s = carry_q;
        end
`else
        hazard    = ex_valid && ex_uses_cin && wb_pending;
        cin_src_s = carry_q;
`endif
        if (ex_valid && ex_uses_cin) begin
            alu_cin = cin_src_s;
        end else begin
            alu_cin = 1'b0;
        end
    end

    // Flag state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage EX/WB wrapper around an external combinational 8-bit ALU with valid/ready handshakes.
// Optional macro ALU_ISSUE_FLAG_FWD_EN: forward WB carry to EX instead of stalling.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int W   = 8,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_op,
    input  logic [2:0]     in_sc,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic           in_wflag,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [4:0]     alu_fn,
    output logic [2:0]     alu_sc,
    output logic           alu_cin,
    input  logic [W-1:0]   alu_y,
    input  logic           alu_cout,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_y,
    output logic           out_cout,
    output logic           out_zero,
    output logic           out_illegal,
    output logic           carry_flag,
    output logic           zero_flag
);

    logic           ex_valid_q, ex_valid_d;
    logic [OPW-1:0] ex_op_q, ex_op_d;
    logic [2:0]     ex_sc_q, ex_sc_d;
    logic [W-1:0]   ex_a_q, ex_a_d;
    logic [W-1:0]   ex_b_q, ex_b_d;
    logic           ex_wflag_q, ex_wflag_d;

    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_y_q, out_y_d;
    logic           out_cout_q, out_cout_d;
    logic           out_zero_q, out_zero_d;
    logic           out_illegal_q, out_illegal_d;
    logic           wb_wflag_q, wb_wflag_d;
    logic [OPW-1:0] wb_op_q, wb_op_d;

    logic wb_free_s, ex_adv_s, accept_s, hazard_s, ex_illegal_s;

    // Handshake: EX advances into a free WB unless waiting on an uncommitted carry.
    always_comb begin
        ex_illegal_s = is_illegal(ex_op_q);
        wb_free_s    = !out_valid_q || out_ready;
        ex_adv_s     = ex_valid_q && wb_free_s && !hazard_s;
        in_ready     = rst_n && (!ex_valid_q || ex_adv_s);
        accept_s     = in_valid && in_ready;
    end

    // EX stage next state.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_op_d    = ex_op_q;
        ex_sc_d    = ex_sc_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_wflag_d = ex_wflag_q;
        if (accept_s) begin
            ex_valid_d = 1'b1;
            ex_op_d    = in_op;
            ex_sc_d    = in_sc;
            ex_a_d     = in_a;
            ex_b_d     = in_b;
            ex_wflag_d = in_wflag;
        end else if (ex_adv_s) begin
            ex_valid_d = 1'b0;
        end else begin
            ex_valid_d = ex_valid_q;
        end
    end

    // WB stage next state; illegal ops retire as an all-zero result with the illegal marker.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_y_d       = out_y_q;
        out_cout_d    = out_cout_q;
        out_zero_d    = out_zero_q;
        out_illegal_d = out_illegal_q;
        wb_wflag_d    = wb_wflag_q;
        wb_op_d       = wb_op_q;
        if (ex_adv_s) begin
            out_valid_d = 1'b1;
            wb_wflag_d  = ex_wflag_q;
            wb_op_d     = ex_op_q;
            if (ex_illegal_s) begin
                out_y_d       = {W{1'b0}};
                out_cout_d    = 1'b0;
                out_zero_d    = 1'b0;
                out_illegal_d = 1'b1;
            end else begin
                out_y_d       = alu_y;
                out_cout_d    = sets_carry(ex_op_q) ? alu_cout : 1'b0;
                out_zero_d    = (alu_y == {W{1'b0}});
                out_illegal_d = 1'b0;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_op_q       <= {OPW{1'b0}};
            ex_sc_q       <= 3'd0;
            ex_a_q        <= {W{1'b0}};
            ex_b_q        <= {W{1'b0}};
            ex_wflag_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_y_q       <= {W{1'b0}};
            out_cout_q    <= 1'b0;
            out_zero_q    <= 1'b0;
            out_illegal_q <= 1'b0;
            wb_wflag_q    <= 1'b0;
            wb_op_q       <= {OPW{1'b0}};
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_op_q       <= ex_op_d;
            ex_sc_q       <= ex_sc_d;
            ex_a_q        <= ex_a_d;
            ex_b_q        <= ex_b_d;
            ex_wflag_q    <= ex_wflag_d;
            out_valid_q   <= out_valid_d;
            out_y_q       <= out_y_d;
            out_cout_q    <= out_cout_d;
            out_zero_q    <= out_zero_d;
            out_illegal_q <= out_illegal_d;
            wb_wflag_q    <= wb_wflag_d;
            wb_op_q       <= wb_op_d;
        end
    end

    alu_flag_reg u_flags (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid_q),
        .ex_uses_cin   (uses_cin(ex_op_q)),
        .wb_pending    (out_valid_q && wb_wflag_q),
        .wb_ready      (out_ready),
        .wb_illegal    (out_illegal_q),
        .wb_sets_carry (sets_carry(wb_op_q)),
        .wb_cout       (out_cout_q),
        .wb_zero       (out_zero_q),
        .carry_flag    (carry_flag),
        .zero_flag     (zero_flag),
        .alu_cin       (alu_cin),
        .hazard        (hazard_s)
    );

    assign alu_a       = ex_a_q;
    assign alu_b       = ex_b_q;
    assign alu_sc      = ex_sc_q;
    assign alu_fn      = ex_illegal_s ? 5'd0 : {1'b0, ex_op_q};
    assign out_valid   = out_valid_q;
    assign out_y       = out_y_q;
    assign out_cout    = out_cout_q;
    assign out_zero    = out_zero_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: bench-side ALU, sequential reference model, directed + random ops.
module tb_alu_issue_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid, in_ready, in_wflag;
    logic [3:0] in_op;
    logic [2:0] in_sc, alu_sc;
    logic [7:0] in_a, in_b, alu_a, alu_b, alu_y, out_y;
    logic [4:0] alu_fn;
    logic       alu_cin, alu_cout;
    logic       out_valid, out_ready, out_cout, out_zero, out_illegal;
    logic       carry_flag, zero_flag;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_sc(in_sc),
        .in_a(in_a), .in_b(in_b), .in_wflag(in_wflag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .alu_sc(alu_sc), .alu_cin(alu_cin),
        .alu_y(alu_y), .alu_cout(alu_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_cout(out_cout),
        .out_zero(out_zero), .out_illegal(out_illegal),
        .carry_flag(carry_flag), .zero_flag(zero_flag)
    );

    // Behavioural ALU semantics: returns {carry, result} using integer arithmetic.
    function automatic logic [8:0] alu_model(input int op, input int a, input int b, input int sc, input int cin);
        int r, t, y;
        case (op)
            0:  r = a + b;
            1:  r = a + b + cin;
            2:  r = a + (255 - b) + 1;
            3:  r = a + (255 - b) + cin;
            4:  r = a & b;
            5:  r = a | b;
            6:  r = a ^ b;
            7:  r = a & (255 - b);
            8:  begin t = a << sc; r = (t & 255) | ((sc != 0) ? (t & 256) : 0); end
            9:  begin t = (a << 8) >> sc; r = (t >> 8) | (((sc != 0) && ((t >> 7) & 1) == 1) ? 256 : 0); end
            10: begin y = ((a << sc) | (a >> (8 - sc))) & 255; r = y | (((sc != 0) && (y & 1) == 1) ? 256 : 0); end
            11: begin y = ((a >> sc) | (a << (8 - sc))) & 255; r = y | (((sc != 0) && ((y >> 7) & 1) == 1) ? 256 : 0); end
            default: r = 0;
        endcase
        return r[8:0];
    endfunction

    always_comb {alu_cout, alu_y} = alu_model(int'(alu_fn), int'(alu_a), int'(alu_b), int'(alu_sc), int'(alu_cin));

    typedef struct {
        logic [7:0] y;
        logic cout, zero, ill, cf, zf;
    } exp_t;

    exp_t q[$];
    logic model_carry = 1'b0, model_zero = 1'b0;
    logic pend = 1'b0, pend_cf, pend_zf;
    logic rand_rdy = 1'b0;
    int n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: sequential in-order semantics, evaluated when an op is accepted.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_t e;
            logic [8:0] r;
            logic setc;
            e.ill = (in_op >= 4'd12);
            setc  = (in_op <= 4'd3) || ((in_op >= 4'd8) && (in_op <= 4'd11));
            if (e.ill) begin
                e.y = 8'h00; e.cout = 1'b0; e.zero = 1'b0;
            end else begin
                r = alu_model(int'(in_op), int'(in_a), int'(in_b), int'(in_sc), int'(model_carry));
                e.y = r[7:0];
                e.cout = setc ? r[8] : 1'b0;
                e.zero = (r[7:0] == 8'h00);
                if (in_wflag) begin
                    model_zero = e.zero;
                    if (setc) model_carry = e.cout;
                end
            end
            e.cf = model_carry;
            e.zf = model_zero;
            q.push_back(e);
        end
    end

    // Monitor: compares each retiring result and, one cycle later, the committed flags.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("carry_flag", carry_flag, pend_cf);
                chk("zero_flag", zero_flag, pend_zf);
                pend = 1'b0;
            end
            if (alu_fn[3:0] != 4'd1 && alu_fn[3:0] != 4'd3) chk("alu_cin_gate", alu_cin, 0);
            if (out_valid && out_ready) begin
                chk("expected_pending", q.size() > 0, 1);
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_y", out_y, e.y);
                    chk("out_cout", out_cout, e.cout);
                    chk("out_zero", out_zero, e.zero);
                    chk("out_illegal", out_illegal, e.ill);
                    pend = 1'b1; pend_cf = e.cf; pend_zf = e.zf;
                end
            end
        end
    end

    // Random downstream backpressure when enabled.
    initial forever begin
        @(posedge clk); #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] sc, input logic wf, output int stalls);
        logic rdy;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_sc = sc; in_wflag = wf;
        stalls = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin
                in_valid = 1'b0;
                return;
            end
            stalls++;
        end
        in_valid = 1'b0;
        chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (q.size() == 0 && !pend) return;
            @(posedge clk); #1;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic test_add_f0();
        int st;
        send(4'd0, 8'hF0, 8'h20, 3'd0, 1'b1, st);
        chk("lat_ex_not_out", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_out_valid", out_valid, 1);
        chk("t1_out_y", out_y, 8'h10);
        drain();
        chk("t1_carry", carry_flag, 1);
    endtask

    initial begin
        int st;
        in_valid = 1'b0; in_op = 4'd0; in_a = 8'h00; in_b = 8'h00; in_sc = 3'd0; in_wflag = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_carry", carry_flag, 0);
        chk("rst_zero", zero_flag, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_alu_a", alu_a, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);

        test_add_f0();

        // Back-to-back carry dependency; the third op exposes the bubble.
        send(4'd0, 8'hFF, 8'h01, 3'd0, 1'b1, st);
        send(4'd1, 8'h00, 8'h00, 3'd0, 1'b1, st);
        send(4'd5, 8'h0F, 8'hF0, 3'd0, 1'b0, st);
`ifdef ALU_ISSUE_FLAG_FWD_EN
        chk("t2_bubbles", st, 0);
`else
        chk("t2_bubbles", st, 1);
`endif
        drain();

        send(4'd2, 8'h05, 8'h03, 3'd0, 1'b1, st);
        send(4'd4, 8'hAA, 8'h55, 3'd0, 1'b1, st);
        drain();
        chk("t3_zero_flag", zero_flag, 1);
        chk("t3_carry_kept", carry_flag, 1);

        // Backpressure: two ops held, third offered and blocked.
        out_ready = 1'b0;
        send(4'd0, 8'h11, 8'h22, 3'd0, 1'b0, st);
        send(4'd6, 8'h0F, 8'h01, 3'd0, 1'b0, st);
        in_valid = 1'b1; in_op = 4'd5; in_a = 8'h80; in_b = 8'h01; in_sc = 3'd0; in_wflag = 1'b0;
        repeat (5) begin
            chk("t4_in_ready", in_ready, 0);
            chk("t4_out_valid", out_valid, 1);
            chk("t4_out_y_held", out_y, 8'h33);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(4'd5, 8'h80, 8'h01, 3'd0, 1'b0, st);
        drain();

        send(4'hD, 8'h12, 8'h34, 3'd0, 1'b1, st);
        send(4'd8, 8'h81, 8'h00, 3'd1, 1'b1, st);
        drain();
        chk("t5_carry", carry_flag, 1);

        // Asynchronous reset with two ops in flight.
        send(4'd0, 8'h01, 8'h01, 3'd0, 1'b1, st);
        send(4'd0, 8'h02, 8'h02, 3'd0, 1'b1, st);
        #2 rst_n = 1'b0;
        q.delete(); model_carry = 1'b0; model_zero = 1'b0;
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_carry", carry_flag, 0);
        chk("t6_zero", zero_flag, 0);
        chk("t6_in_ready", in_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        test_add_f0();

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), st);
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
